// File: rtl/axis_pkt_arbiter_pkg.sv
// axis_pkt_arbiter shared definitions
// arbitration type codes and select-width helper
package axis_pkt_arbiter_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // mux select width, never below one bit
    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_pkt_arb_prio.sv
// axis_pkt_arb_prio: masked priority encoder
// request & mask -> one-hot winner, encoded index, valid
import axis_pkt_arbiter_pkg::*;

module axis_pkt_arb_prio #(
    parameter int PORTS    = 4,
    parameter bit LSB_HIGH = 1'b1,
    parameter int SW       = sel_w(PORTS)
) (
    input  logic [PORTS-1:0] request,
    input  logic [PORTS-1:0] mask,
    output logic [PORTS-1:0] onehot,
    output logic [SW-1:0]    encoded,
    output logic             valid
);

    logic [PORTS-1:0] masked;

    // later loop iterations overwrite earlier ones, so scan order picks the winner
    always_comb begin
        masked  = request & mask;
        valid   = |masked;
        onehot  = '0;
        encoded = '0;
        if (LSB_HIGH) begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (masked[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    encoded   = SW'(i);
                end
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (masked[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    encoded   = SW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-level arbiter for one switch output
// holds each grant from first beat to tlast; stall watchdog on grantee
import axis_pkt_arbiter_pkg::*;

module axis_pkt_arbiter #(
    parameter int PORTS                 = 4,
    parameter int ARB_TYPE_ROUND_ROBIN  = 1,
    parameter bit ARB_LSB_HIGH_PRIORITY = 1'b1,
    parameter int STALL_TIMEOUT         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS-1:0]           s_axis_tvalid,
    input  logic [PORTS-1:0]           s_axis_tlast,
    output logic [PORTS-1:0]           s_axis_tready,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [PORTS-1:0]           grant,
    output logic                       grant_valid,
    output logic [$clog2(PORTS)-1:0]   grant_encoded,
    output logic                       stall_err
);

    localparam int SW = sel_w(PORTS);

    // grant_valid is the state; no separate state register
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // MSB-high rotation mirrors LSB-high: highest index first after reset
    localparam logic [SW-1:0] LAST_RST =
        ARB_LSB_HIGH_PRIORITY ? SW'(PORTS - 1) : '0;

    logic [SW-1:0]    last;
    logic [PORTS-1:0] rr_mask;
    logic [PORTS-1:0] m_onehot, a_onehot, sel_onehot;
    logic [SW-1:0]    m_enc, a_enc, sel_enc;
    logic             m_valid, a_valid;
    logic             beat, rel, load;

    // ports strictly after the last grantee in rotation order
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (ARB_LSB_HIGH_PRIORITY)
                rr_mask[i] = (i > int'(last));
            else
                rr_mask[i] = (i < int'(last));
        end
    end

    axis_pkt_arb_prio #(
        .PORTS    (PORTS),
        .LSB_HIGH (ARB_LSB_HIGH_PRIORITY),
        .SW       (SW)
    ) u_prio_masked (
        .request (s_axis_tvalid),
        .mask    (rr_mask),
        .onehot  (m_onehot),
        .encoded (m_enc),
        .valid   (m_valid)
    );

    axis_pkt_arb_prio #(
        .PORTS    (PORTS),
        .LSB_HIGH (ARB_LSB_HIGH_PRIORITY),
        .SW       (SW)
    ) u_prio_all (
        .request (s_axis_tvalid),
        .mask    ({PORTS{1'b1}}),
        .onehot  (a_onehot),
        .encoded (a_enc),
        .valid   (a_valid)
    );

    // winner select, release detection and handshake gating
    always_comb begin
        if (ARB_TYPE_ROUND_ROBIN == ARB_RR && m_valid) begin
            sel_onehot = m_onehot;
            sel_enc    = m_enc;
        end else begin
            sel_onehot = a_onehot;
            sel_enc    = a_enc;
        end
        s_axis_tready = grant & {PORTS{m_axis_tready}};
        m_axis_tvalid = grant_valid & |(s_axis_tvalid & grant);
        beat = m_axis_tvalid & m_axis_tready;
        rel  = (grant_valid == ST_ACTIVE) & beat
             & s_axis_tlast[grant_encoded];
        load = ((grant_valid == ST_IDLE) | rel) & a_valid;
    end

    // grant register: load winner, hold through packet, drop when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
            last          <= LAST_RST;
        end else if (load) begin
            grant         <= sel_onehot;
            grant_valid   <= 1'b1;
            grant_encoded <= sel_enc;
            last          <= sel_enc;
        end else if (rel) begin
            grant       <= '0;
            grant_valid <= 1'b0;
        end
    end

    if (STALL_TIMEOUT > 0) begin : g_wd
        localparam int CW = $clog2(STALL_TIMEOUT + 1);
        localparam logic [CW-1:0] TO   = CW'(STALL_TIMEOUT);
        localparam logic [CW-1:0] TO_1 = CW'(STALL_TIMEOUT - 1);

        logic [CW-1:0] cnt;
        logic          idle;

        assign idle = grant_valid & ~s_axis_tvalid[grant_encoded];

        // count idle grantee cycles; pulse once on reaching the limit
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt       <= '0;
                stall_err <= 1'b0;
            end else begin
                stall_err <= 1'b0;
                if (!grant_valid || beat || load) begin
                    cnt <= '0;
                end else if (idle && cnt != TO) begin
                    cnt       <= cnt + 1'b1;
                    stall_err <= (cnt == TO_1);
                end
            end
        end
    end else begin : g_no_wd
        assign stall_err = 1'b0;
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed checks of grant sequencing,
// handshake gating, fixed priority and stall watchdog
module tb_axis_pkt_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tvalid = '0;
    logic [3:0] tlast  = '0;
    logic       mready = 1'b0;

    logic [3:0] rr_tready, rr_grant, fp_tready, fp_grant;
    logic       rr_mvalid, rr_gv, rr_stall;
    logic       fp_mvalid, fp_gv, fp_stall;
    logic [1:0] rr_enc, fp_enc;

    int total = 0;
    int pass  = 0;
    int fail  = 0;

    always #5 clk = ~clk;

    axis_pkt_arbiter #(
        .PORTS                 (4),
        .ARB_TYPE_ROUND_ROBIN  (1),
        .ARB_LSB_HIGH_PRIORITY (1'b1),
        .STALL_TIMEOUT         (5)
    ) u_rr (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (rr_tready),
        .m_axis_tready (mready),
        .m_axis_tvalid (rr_mvalid),
        .grant         (rr_grant),
        .grant_valid   (rr_gv),
        .grant_encoded (rr_enc),
        .stall_err     (rr_stall)
    );

    axis_pkt_arbiter #(
        .PORTS                 (4),
        .ARB_TYPE_ROUND_ROBIN  (0),
        .ARB_LSB_HIGH_PRIORITY (1'b1),
        .STALL_TIMEOUT         (0)
    ) u_fp (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (fp_tready),
        .m_axis_tready (mready),
        .m_axis_tvalid (fp_mvalid),
        .grant         (fp_grant),
        .grant_valid   (fp_gv),
        .grant_encoded (fp_enc),
        .stall_err     (fp_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else begin
            fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_grant",  32'(rr_grant),  32'h0);
        chk("rst_gv",     32'(rr_gv),     32'h0);
        chk("rst_enc",    32'(rr_enc),    32'h0);
        chk("rst_stall",  32'(rr_stall),  32'h0);
        chk("rst_tready", 32'(rr_tready), 32'h0);
        chk("rst_mvalid", 32'(rr_mvalid), 32'h0);
        chk("rst_fp_gv",  32'(fp_gv),     32'h0);

        // all request, no tlast: port 0 wins and holds
        tvalid = 4'b1111;
        tlast  = 4'b0000;
        mready = 1'b1;
        rst    = 1'b0;
        tick();
        chk("t1_grant",  32'(rr_grant),  32'h1);
        chk("t1_enc",    32'(rr_enc),    32'h0);
        chk("t1_gv",     32'(rr_gv),     32'h1);
        chk("t1_tready", 32'(rr_tready), 32'h1);
        chk("t1_mvalid", 32'(rr_mvalid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_hold", 32'(rr_grant), 32'h1);
        end

        // 2-beat packets from all ports: 0,0,1,1,2,2,3,3,0,0
        tvalid = 4'b1111;
        tlast  = 4'b0000;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_grant",  32'(rr_grant),  32'(4'b0001 << ((i / 2) % 4)));
            chk("t2_tready", 32'(rr_tready), 32'(4'b0001 << ((i / 2) % 4)));
            chk("t2_gv",     32'(rr_gv),     32'h1);
            tlast = (i % 2 == 1) ? 4'b1111 : 4'b0000;
        end

        // single-beat packets from ports 1 and 3
        tvalid = 4'b1010;
        tlast  = 4'b1111;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_fp_grant", 32'(fp_grant), 32'h2);
            chk("t3_rr_grant", 32'(rr_grant), (i % 2 == 0) ? 32'h2 : 32'h8);
        end

        // grantee port 2 drops valid while port 0 requests
        tvalid = 4'b0100;
        tlast  = 4'b0000;
        do_reset();
        tick();
        chk("t4_grant0", 32'(rr_grant), 32'h4);
        tvalid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_grant",   32'(rr_grant),     32'h4);
            chk("t4_p0rdy",   32'(rr_tready[0]), 32'h0);
            chk("t4_tready",  32'(rr_tready),    32'h4);
            chk("t4_mvalid",  32'(rr_mvalid),    32'h0);
            chk("t4_stall",   32'(rr_stall),     32'h0);
        end

        // tlast presented with downstream stalled: no release
        tvalid = 4'b0101;
        tlast  = 4'b0100;
        mready = 1'b0;
        tick();
        chk("t5_grant_a",  32'(rr_grant),  32'h4);
        chk("t5_mvalid",   32'(rr_mvalid), 32'h1);
        chk("t5_tready",   32'(rr_tready), 32'h0);
        tick();
        chk("t5_grant_b",  32'(rr_grant),  32'h4);
        mready = 1'b1;
        #1;
        chk("t5_tready_up", 32'(rr_tready), 32'h4);
        tick();
        chk("t5_next",     32'(rr_grant),  32'h1);
        chk("t5_next_enc", 32'(rr_enc),    32'h0);
        chk("t5_next_gv",  32'(rr_gv),     32'h1);

        // watchdog: grantee idle 8 cycles, pulse on the 5th
        tvalid = 4'b0001;
        tlast  = 4'b0000;
        do_reset();
        tick();
        chk("t6_grant0", 32'(rr_grant), 32'h1);
        tvalid = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6_stall", 32'(rr_stall), (k == 5) ? 32'h1 : 32'h0);
            chk("t6_grant", 32'(rr_grant), 32'h1);
        end
        tvalid = 4'b0001;
        tick();
        chk("t6_beat_stall", 32'(rr_stall), 32'h0);
        tvalid = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t6_restall", 32'(rr_stall), (k == 5) ? 32'h1 : 32'h0);
        end
        chk("t6_gv", 32'(rr_gv), 32'h1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
